// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencer: register map, CTRL bits, FSM states.
package booth_pkg;

    localparam logic [1:0] ADDR_A    = 2'd0;
    localparam logic [1:0] ADDR_B    = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    // CTRL write bits: START, DONE (W1C), IRQ_EN; CTRL read bits: BUSY, DONE, IRQ_EN
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_DONE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_BUSY   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of m, then arithmetic shift of {acc,q,q_m1}.
module booth_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_next  = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Avalon-MM sequencer for a radix-2 signed Booth multiplier with done interrupt and LED mirror.
module booth_mul_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OUT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [OUT_W-1:0] out_port,
    output logic             irq
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH:0]     m;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        result;
    logic               done;
    logic               irq_en;

    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_m1_next;
    logic [PROD_W-1:0]  prod;

    logic               wr;
    logic               busy;
    logic               wr_a;
    logic               wr_b;
    logic               wr_ctrl;
    logic               start;
    logic               done_clr;
    logic               unused_wdata;

    assign wr       = chipselect & ~write_n;
    assign busy     = (state != IDLE);
    assign wr_a     = wr && (address == ADDR_A) && !busy;
    assign wr_b     = wr && (address == ADDR_B) && !busy;
    assign wr_ctrl  = wr && (address == ADDR_CTRL);
    assign start    = wr_ctrl && writedata[CTRL_START] && !busy;
    assign done_clr = wr_ctrl && writedata[CTRL_DONE];
    assign prod     = {acc[WIDTH-1:0], q};

    assign unused_wdata = ^writedata;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // Register file, sequencer FSM and iteration counter; later assignments take priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            m      <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (wr_a) a_reg <= writedata[WIDTH-1:0];
            if (wr_b) b_reg <= writedata[WIDTH-1:0];
            if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
            if (done_clr) done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        done  <= 1'b0;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    q     <= b_reg;
                    q_m1  <= 1'b0;
                    m     <= {a_reg[WIDTH-1], a_reg};
                    cnt   <= CNT_W'(WIDTH);
                    state <= RUN;
                end
                RUN: begin
                    acc  <= acc_next;
                    q    <= q_next;
                    q_m1 <= q_m1_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= FINISH;
                end
                FINISH: begin
                    result <= 32'($signed(prod));
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_A:    readdata = 32'($signed(a_reg));
            ADDR_B:    readdata = 32'($signed(b_reg));
            ADDR_CTRL: begin
                readdata[CTRL_BUSY]   = busy;
                readdata[CTRL_DONE]   = done;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_RES:  readdata = result;
            default:   readdata = '0;
        endcase
    end

    assign out_port = result[OUT_W-1:0];
    assign irq      = done & irq_en;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Scoreboard bench for booth_mul_ctrl: stimulus queues expected values, a negedge monitor compares.
module tb_booth_mul_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OUT_W = 6;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_IRQ = 2;

    typedef struct {
        int          kind;
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [OUT_W-1:0] out_port;
    logic             irq;

    exp_t sb[$];
    logic chk_req;
    int   n_checks;
    int   n_errors;

    booth_mul_ctrl #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per requested sample, away from the active edge
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t        e;
            logic [31:0] act;
            n_checks = n_checks + 1;
            if (sb.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL scoreboard_empty: sample requested with no expectation queued");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    K_OUT:   act = 32'(out_port);
                    K_IRQ:   act = 32'(irq);
                    default: act = readdata;
                endcase
                if (act !== e.exp) begin
                    n_errors = n_errors + 1;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // All tasks are entered and left one time unit after a rising edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk(input int kind, input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.exp  = exp;
        e.name = name;
        address = a;
        sb.push_back(e);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        address = 2'd2;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (readdata[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        if (!seen) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL %s: done not seen within 200 cycles, ctrl=0x%08h expected done=1", name, readdata);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        chk_req    = 1'b0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk(K_RD,  2'd0, 32'h0, "reset_a");
        chk(K_RD,  2'd2, 32'h0, "reset_ctrl");
        chk(K_RD,  2'd3, 32'h0, "reset_result");
        chk(K_OUT, 2'd0, 32'h0, "reset_out_port");
        chk(K_IRQ, 2'd0, 32'h0, "reset_irq");

        // 3 x 5: busy for exactly WIDTH+2 cycles, then done
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h1);
        for (int k = 0; k <= 18; k++)
            chk(K_RD, 2'd2, (k < 18) ? 32'h1 : 32'h2, $sformatf("busy_window_k%0d", k));
        chk(K_RD,  2'd3, 32'h0000000F, "result_3x5");
        chk(K_OUT, 2'd0, 32'h0F,       "out_port_3x5");
        chk(K_IRQ, 2'd0, 32'h0,        "irq_disabled");

        // Writes to A and a second start while busy are ignored
        wr(2'd2, 32'h1);
        idle(4);
        wr(2'd0, 32'd9);
        wr(2'd2, 32'h1);
        wait_done("busy_ignore_run");
        chk(K_RD, 2'd3, 32'h0000000F, "result_after_ignored_writes");
        chk(K_RD, 2'd0, 32'h00000003, "a_unchanged");
        chk(K_RD, 2'd2, 32'h00000002, "ctrl_done_only");

        // Reset during RUN aborts
        wr(2'd2, 32'h1);
        idle(8);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk(K_RD,  2'd2, 32'h0, "abort_ctrl");
        chk(K_RD,  2'd3, 32'h0, "abort_result");
        chk(K_OUT, 2'd0, 32'h0, "abort_out_port");
        chk(K_RD,  2'd0, 32'h0, "abort_a");
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'h1);
        wait_done("run_2x2");
        chk(K_RD, 2'd3, 32'h00000004, "result_2x2");

        // -7 x 6 with interrupt enabled
        wr(2'd0, 32'h0000FFF9);
        wr(2'd1, 32'd6);
        wr(2'd2, 32'h5);
        wait_done("run_m7x6");
        chk(K_RD,  2'd3, 32'hFFFFFFD6, "result_m7x6");
        chk(K_IRQ, 2'd0, 32'h1,        "irq_asserted");
        chk(K_OUT, 2'd0, 32'h16,       "out_port_m7x6");
        chk(K_RD,  2'd0, 32'hFFFFFFF9, "a_sign_extended");
        wr(2'd2, 32'h6);
        chk(K_IRQ, 2'd0, 32'h0,        "irq_after_w1c");
        chk(K_RD,  2'd2, 32'h4,        "ctrl_after_w1c");
        wr(2'd2, 32'h0);

        // Most-negative operand corners
        wr(2'd0, 32'h00008000);
        wr(2'd1, 32'h00008000);
        wr(2'd2, 32'h1);
        wait_done("run_min_x_min");
        chk(K_RD,  2'd3, 32'h40000000, "result_min_x_min");
        chk(K_RD,  2'd1, 32'hFFFF8000, "b_sign_extended");
        wr(2'd1, 32'h00000001);
        wr(2'd2, 32'h1);
        wait_done("run_min_x_1");
        chk(K_RD,  2'd3, 32'hFFFF8000, "result_min_x_1");
        chk(K_OUT, 2'd0, 32'h00,       "out_port_min_x_1");

        // Old RESULT holds until FINISH; back-to-back start combined with done W1C
        wr(2'd0, 32'h0000FFFD);
        wr(2'd1, 32'd7);
        wr(2'd2, 32'h1);
        for (int k = 0; k < 18; k++)
            chk(K_RD, 2'd3, 32'hFFFF8000, $sformatf("result_hold_k%0d", k));
        chk(K_RD,  2'd3, 32'hFFFFFFEB, "result_m3x7");
        wr(2'd2, 32'h3);
        chk(K_RD,  2'd2, 32'h1,        "start_wins_over_w1c");
        wait_done("run_back_to_back");
        chk(K_RD,  2'd3, 32'hFFFFFFEB, "result_back_to_back");
        chk(K_OUT, 2'd0, 32'h2B,       "out_port_m3x7");
        chk(K_RD,  2'd2, 32'h2,        "ctrl_final");

        idle(2);
        if (sb.size() != 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
